// File: rtl/fifo_burst_reader.sv
// ============================================================================
// fifo_burst_reader : drains a synchronous FIFO in len-word bursts onto a
// valid/ready stream through a 3-entry skid buffer.            Rev 1.0
// ============================================================================
`default_nettype none

module fifo_burst_reader #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              empty,
   output logic              r_en,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  rd_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_READ = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam int         DEPTH  = 3;

   logic [1:0]                   state_q,    state_d;
   logic [LEN_W-1:0]             len_q,      len_d;
   logic [LEN_W-1:0]             issued_q,   issued_d;
   logic [LEN_W-1:0]             rd_count_q, rd_count_d;
   logic                         inflight_q, inflight_d;
   logic [1:0]                   occ_q,      occ_d;
   logic [DEPTH-1:0][DATA_W-1:0] buf_q,      buf_d;

   logic                         r_en_w;
   logic                         push;
   logic                         pop;
   logic [1:0]                   occ_after_pop;
   logic [LEN_W-1:0]             rd_count_inc;

   // Credit counts the word still in flight so the buffer can never overflow.
   assign r_en_w = (state_q == S_READ) && !empty && (issued_q < len_q) &&
                   (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
   assign push          = inflight_q;
   assign pop           = (occ_q != 2'd0) && m_ready;
   assign occ_after_pop = pop ? (occ_q - 2'd1) : occ_q;
   assign rd_count_inc  = rd_count_q + {{(LEN_W-1){1'b0}}, 1'b1};

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      issued_d   = issued_q;
      rd_count_d = rd_count_q;
      inflight_d = r_en_w;
      occ_d      = occ_q;
      buf_d      = buf_q;

      if (r_en_w) begin
         issued_d = issued_q + {{(LEN_W-1){1'b0}}, 1'b1};
      end
      if (pop) begin
         rd_count_d = rd_count_inc;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d      = len;
               rd_count_d = '0;
               issued_d   = '0;
               state_d    = (len == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            if (pop && (rd_count_inc == len_q)) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Head keeps its last value when the final entry leaves.
      if (pop && (occ_q > 2'd1)) begin
         buf_d[0] = buf_q[1];
         buf_d[1] = buf_q[2];
      end
      if (push) begin
         case (occ_after_pop)
            2'd0:    buf_d[0] = data_in;
            2'd1:    buf_d[1] = data_in;
            2'd2:    buf_d[2] = data_in;
            default: buf_d    = buf_d;
         endcase
      end

      if (push && !pop) begin
         occ_d = occ_q + 2'd1;
      end else if (!push && pop) begin
         occ_d = occ_q - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         issued_q   <= '0;
         rd_count_q <= '0;
         inflight_q <= 1'b0;
         occ_q      <= 2'd0;
         buf_q      <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         issued_q   <= issued_d;
         rd_count_q <= rd_count_d;
         inflight_q <= inflight_d;
         occ_q      <= occ_d;
         buf_q      <= buf_d;
      end
   end

   assign r_en     = r_en_w;
   assign m_valid  = (occ_q != 2'd0);
   assign m_data   = buf_q[0];
   assign busy     = (state_q == S_READ);
   assign done     = (state_q == S_DONE);
   assign rd_count = rd_count_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
// ============================================================================
// tb_fifo_burst_reader : directed bench with FIFO model and word scoreboard
// for fifo_burst_reader.                                       Rev 1.0
// ============================================================================
`default_nettype none

module tb_fifo_burst_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] len;
   logic       empty;
   logic       r_en;
   logic [7:0] data_in = 8'h00;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       busy;
   logic       done;
   logic [7:0] rd_count;

   int checks   = 0;
   int errors   = 0;
   int ren_cnt  = 0;
   int done_cnt = 0;
   int wr_ptr   = 0;
   int rd_ptr   = 0;
   int rb;
   int db;
   int n;

   logic [7:0] fifo_mem [256];
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   fifo_burst_reader #(.DATA_W(8), .LEN_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .len      (len),
      .empty    (empty),
      .r_en     (r_en),
      .data_in  (data_in),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .busy     (busy),
      .done     (done),
      .rd_count (rd_count)
   );

   // Synchronous FIFO model: read data appears the cycle after r_en.
   assign empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      ren_cnt <= ren_cnt + ((r_en === 1'b1) ? 1 : 0);
      if (r_en === 1'b1) begin
         data_in <= fifo_mem[rd_ptr[7:0]];
         rd_ptr  <= rd_ptr + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fifo_put(input logic [7:0] b, input bit expect_out);
      fifo_mem[wr_ptr[7:0]] = b;
      wr_ptr = wr_ptr + 1;
      if (expect_out) exp_q.push_back(b);
   endtask

   // Handshake seen now is the one the next rising edge accepts.
   task automatic tick();
      if (rst === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL extra_word observed=%0h expected=none", m_data);
         end
         if (exp_q.size() != 0) check("word", m_data, exp_q.pop_front());
      end
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
   endtask

   task automatic wait_done(input string tag, input int max);
      int k;
      k = 0;
      while (done !== 1'b1 && k < max) begin
         tick();
         k++;
      end
      check(tag, done, 32'd1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; len = 8'd0; m_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_r_en",     r_en,     32'd0);
      check("rst_m_valid",  m_valid,  32'd0);
      check("rst_m_data",   m_data,   32'd0);
      check("rst_busy",     busy,     32'd0);
      check("rst_done",     done,     32'd0);
      check("rst_rd_count", rd_count, 32'd0);
      rst = 1'b0;
      tick();

      // Single word
      fifo_put(8'hFA, 1'b1);
      m_ready = 1'b1; len = 8'd1; start = 1'b1;
      rb = ren_cnt; db = done_cnt;
      tick(); start = 1'b0;
      check("sw_busy_e1", busy, 32'd1);
      check("sw_ren_e1",  r_en, 32'd1);
      tick();
      check("sw_ren_e2",    r_en,    32'd0);
      check("sw_mvalid_e2", m_valid, 32'd0);
      tick();
      check("sw_mvalid_e3", m_valid, 32'd1);
      check("sw_mdata_e3",  m_data,  32'hFA);
      tick();
      check("sw_done_e4",  done,     32'd1);
      check("sw_busy_e4",  busy,     32'd0);
      check("sw_rdcount",  rd_count, 32'd1);
      start = 1'b1; len = 8'd1;
      tick(); start = 1'b0;
      check("sw_done_start_busy", busy, 32'd0);
      tick();
      check("sw_done_start_busy2", busy, 32'd0);
      check("sw_ren_total",  ren_cnt - rb,  32'd1);
      check("sw_done_total", done_cnt - db, 32'd1);

      // Full-rate burst
      for (int i = 1; i <= 4; i++) fifo_put(8'(i), 1'b1);
      len = 8'd4; start = 1'b1;
      rb = ren_cnt; db = done_cnt;
      for (int k = 1; k <= 8; k++) begin
         tick(); start = 1'b0;
         check($sformatf("fr_ren_c%0d", k),    r_en,    {31'd0, (k <= 4)});
         check($sformatf("fr_mvalid_c%0d", k), m_valid, {31'd0, (k >= 3 && k <= 6)});
         check($sformatf("fr_done_c%0d", k),   done,    {31'd0, (k == 7)});
      end
      check("fr_rdcount",    rd_count,      32'd4);
      check("fr_done_total", done_cnt - db, 32'd1);
      check("fr_all_words",  exp_q.size(),  32'd0);

      // Backpressure
      for (int i = 0; i < 8; i++) fifo_put(8'h10 + 8'(i), 1'b1);
      m_ready = 1'b0; len = 8'd8; start = 1'b1;
      rb = ren_cnt;
      for (int k = 1; k <= 10; k++) begin
         tick(); start = 1'b0;
         if (k >= 3) begin
            check($sformatf("bp_mvalid_c%0d", k), m_valid, 32'd1);
            check($sformatf("bp_mdata_c%0d", k),  m_data,  32'h10);
         end
      end
      check("bp_ren_stall", ren_cnt - rb, 32'd3);
      m_ready = 1'b1;
      wait_done("bp_done", 60);
      check("bp_rdcount",   rd_count,     32'd8);
      check("bp_all_words", exp_q.size(), 32'd0);
      tick();

      // Empty stall
      len = 8'd2; start = 1'b1;
      rb = ren_cnt;
      tick(); start = 1'b0;
      check("es_busy", busy, 32'd1);
      check("es_ren",  r_en, 32'd0);
      tick(); tick(); tick();
      check("es_busy_hold", busy,    32'd1);
      check("es_mvalid",    m_valid, 32'd0);
      fifo_put(8'hA5, 1'b1);
      fifo_put(8'h5A, 1'b1);
      wait_done("es_done", 20);
      check("es_rdcount",   rd_count,     32'd2);
      check("es_ren_total", ren_cnt - rb, 32'd2);
      check("es_all_words", exp_q.size(), 32'd0);
      tick();

      // Zero-length burst
      len = 8'd0; start = 1'b1;
      rb = ren_cnt;
      tick(); start = 1'b0;
      check("z_done", done, 32'd1);
      check("z_busy", busy, 32'd0);
      check("z_ren",  r_en, 32'd0);
      tick();
      check("z_done_end",  done,         32'd0);
      check("z_ren_total", ren_cnt - rb, 32'd0);

      // start during READ is ignored
      len = 8'd3; start = 1'b1;
      rb = ren_cnt;
      tick(); start = 1'b0;
      tick();
      len = 8'd7; start = 1'b1;
      tick(); start = 1'b0;
      check("sr_busy", busy, 32'd1);
      fifo_put(8'h31, 1'b1);
      fifo_put(8'h32, 1'b1);
      fifo_put(8'h33, 1'b1);
      fifo_put(8'h34, 1'b0);
      fifo_put(8'h35, 1'b0);
      wait_done("sr_done", 30);
      check("sr_rdcount",   rd_count,        32'd3);
      check("sr_ren_total", ren_cnt - rb,    32'd3);
      check("sr_fifo_left", wr_ptr - rd_ptr, 32'd2);
      check("sr_all_words", exp_q.size(),    32'd0);
      tick();

      // Reset mid-burst after 2 of 4 words
      exp_q.push_back(8'h34);
      exp_q.push_back(8'h35);
      len = 8'd4; start = 1'b1;
      tick(); start = 1'b0;
      n = 0;
      while (rd_count !== 8'd2 && n < 20) begin
         tick();
         n++;
      end
      check("mr_two_words", rd_count, 32'd2);
      check("mr_busy_pre",  busy,     32'd1);
      rst = 1'b1;
      tick();
      check("mr_r_en",     r_en,     32'd0);
      check("mr_m_valid",  m_valid,  32'd0);
      check("mr_m_data",   m_data,   32'd0);
      check("mr_busy",     busy,     32'd0);
      check("mr_done",     done,     32'd0);
      check("mr_rd_count", rd_count, 32'd0);
      fifo_put(8'h23, 1'b0);
      fifo_put(8'h24, 1'b0);
      tick();
      rst = 1'b0;
      tick(); tick();
      check("mr_idle_busy", busy,            32'd0);
      check("mr_idle_ren",  r_en,            32'd0);
      check("mr_fifo_left", wr_ptr - rd_ptr, 32'd2);
      exp_q.push_back(8'h23);
      exp_q.push_back(8'h24);
      len = 8'd2; start = 1'b1;
      tick(); start = 1'b0;
      wait_done("mr_resume_done", 20);
      check("mr_resume_rdcount", rd_count,        32'd2);
      check("mr_resume_words",   exp_q.size(),    32'd0);
      check("mr_fifo_drained",   wr_ptr - rd_ptr, 32'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
